// File: rtl/wave_meas.sv
// Waveform measurement: a prescan window finds min/max and a midpoint threshold,
// then a gate window counts hysteresis-qualified rising crossings of that threshold.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for meas_en
// PRESCAN | tracking min/max of valid samples for GATE_CYCLES cycles
// GATE    | counting armed rising crossings for GATE_CYCLES cycles
// DONE    | one cycle, results published with meas_valid
module wave_meas #(
    parameter logic [31:0] GATE_CYCLES = 32'd50_000_000,
    parameter logic [7:0]  HYST        = 8'd8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ad_data,
    input  logic        ad_valid,
    input  logic        meas_en,
    output logic        busy,
    output logic [7:0]  wave_max,
    output logic [7:0]  wave_min,
    output logic [7:0]  wave_vpp,
    output logic [31:0] freq_cnt,
    output logic        meas_valid
);

    typedef enum logic [1:0] {S_IDLE, S_PRESCAN, S_GATE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] win_cnt_q, win_cnt_d;
    logic [7:0]  max_q, max_d, min_q, min_d;
    logic        seen_q, seen_d;
    logic [7:0]  hi_th_q, hi_th_d, lo_th_q, lo_th_d;
    logic        flat_q, flat_d, arm_q, arm_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  wave_max_q, wave_max_d, wave_min_q, wave_min_d, wave_vpp_q, wave_vpp_d;
    logic [31:0] freq_cnt_q, freq_cnt_d;
    logic        busy_q, busy_d, meas_valid_q, meas_valid_d;

    logic        win_last;
    logic [8:0]  sum9, hi9, span9;
    logic [7:0]  mid;

    assign win_last = (win_cnt_q == GATE_CYCLES - 32'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            win_cnt_q    <= '0;
            max_q        <= '0;
            min_q        <= '0;
            seen_q       <= 1'b0;
            hi_th_q      <= '0;
            lo_th_q      <= '0;
            flat_q       <= 1'b0;
            arm_q        <= 1'b0;
            cnt_q        <= '0;
            wave_max_q   <= '0;
            wave_min_q   <= '0;
            wave_vpp_q   <= '0;
            freq_cnt_q   <= '0;
            busy_q       <= 1'b0;
            meas_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            max_q        <= max_d;
            min_q        <= min_d;
            seen_q       <= seen_d;
            hi_th_q      <= hi_th_d;
            lo_th_q      <= lo_th_d;
            flat_q       <= flat_d;
            arm_q        <= arm_d;
            cnt_q        <= cnt_d;
            wave_max_q   <= wave_max_d;
            wave_min_q   <= wave_min_d;
            wave_vpp_q   <= wave_vpp_d;
            freq_cnt_q   <= freq_cnt_d;
            busy_q       <= busy_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    // Dropping meas_en aborts a running window, even on its last cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (meas_en) state_d = S_PRESCAN;
            S_PRESCAN: if (!meas_en) state_d = S_IDLE; else if (win_last) state_d = S_GATE;
            S_GATE:    if (!meas_en) state_d = S_IDLE; else if (win_last) state_d = S_DONE;
            S_DONE:    state_d = meas_en ? S_PRESCAN : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        win_cnt_d    = '0;
        max_d        = max_q;
        min_d        = min_q;
        seen_d       = seen_q;
        hi_th_d      = hi_th_q;
        lo_th_d      = lo_th_q;
        flat_d       = flat_q;
        arm_d        = arm_q;
        cnt_d        = cnt_q;
        wave_max_d   = wave_max_q;
        wave_min_d   = wave_min_q;
        wave_vpp_d   = wave_vpp_q;
        freq_cnt_d   = freq_cnt_q;
        busy_d       = (state_d == S_PRESCAN) || (state_d == S_GATE);
        meas_valid_d = (state_d == S_DONE);

        if ((state_q == S_PRESCAN || state_q == S_GATE) && state_d == state_q)
            win_cnt_d = win_cnt_q + 32'd1;

        if (state_d == S_PRESCAN && state_q != S_PRESCAN) begin
            max_d  = 8'h00;
            min_d  = 8'hFF;
            seen_d = 1'b0;
        end else if (state_q == S_PRESCAN && ad_valid) begin
            if (ad_data > max_q) max_d = ad_data;
            if (ad_data < min_q) min_d = ad_data;
            seen_d = 1'b1;
        end

        // Thresholds come from the scan values including the last prescan sample.
        sum9  = {1'b0, max_d} + {1'b0, min_d};
        mid   = sum9[8:1];
        hi9   = {1'b0, mid} + {1'b0, HYST};
        span9 = {1'b0, max_d} - {1'b0, min_d};
        if (state_q == S_PRESCAN && state_d == S_GATE) begin
            hi_th_d = hi9[8] ? 8'hFF : hi9[7:0];
            lo_th_d = (mid < HYST) ? 8'h00 : mid - HYST;
            flat_d  = !seen_d || (span9 <= {HYST, 1'b0});
        end

        if (state_d == S_GATE && state_q != S_GATE) begin
            arm_d = 1'b0;
            cnt_d = '0;
        end else if (state_q == S_GATE && ad_valid) begin
            if (ad_data < lo_th_q) begin
                arm_d = 1'b1;
            end else if (ad_data >= hi_th_q && arm_q) begin
                arm_d = 1'b0;
                if (!flat_q && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
            end
        end

        if (state_q == S_GATE && state_d == S_DONE) begin
            wave_max_d = seen_q ? max_q : 8'h00;
            wave_min_d = seen_q ? min_q : 8'h00;
            wave_vpp_d = seen_q ? max_q - min_q : 8'h00;
            freq_cnt_d = cnt_d;
        end
    end

    assign busy       = busy_q;
    assign wave_max   = wave_max_q;
    assign wave_min   = wave_min_q;
    assign wave_vpp   = wave_vpp_q;
    assign freq_cnt   = freq_cnt_q;
    assign meas_valid = meas_valid_q;

endmodule
